m68k_waitgen: RTL and testbench



---
 rtl/m68k_waitgen_if.sv | 25 ++
 rtl/m68k_waitgen.sv | 172 +++++++++++++++++
 tb/tb_m68k_waitgen.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/m68k_waitgen_if.sv
// Bus-side signals between the 68000 cycle, m68kdecoder selects and the
// wait-state generator.
interface m68k_waitgen_if;
    logic       as_n;
    logic       uds_n;
    logic       lds_n;
    logic       rw;
    logic [3:0] cs;
    logic [3:0] rdy;
    logic       dtack_trig;
    logic       berr_req;
    logic       per_rd_n;
    logic       per_wr_n;
    logic       busy;

    modport master (
        output as_n, uds_n, lds_n, rw, cs, rdy,
        input  dtack_trig, berr_req, per_rd_n, per_wr_n, busy
    );

    modport slave (
        input  as_n, uds_n, lds_n, rw, cs, rdy,
        output dtack_trig, berr_req, per_rd_n, per_wr_n, busy
    );
endinterface

// File: rtl/m68k_waitgen.sv
// Per-chip-select wait-state counter with optional ready hold-off, driving
// dtack_trig / berr_req back to the decoder and strobes to the peripheral.
module m68k_waitgen #(
    parameter int unsigned WAIT0    = 2,
    parameter int unsigned WAIT1    = 4,
    parameter int unsigned WAIT2    = 8,
    parameter int unsigned WAIT3    = 15,
    parameter logic [3:0]  RDY_MASK = 4'b0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input logic            clk50,
    input logic            reset,
    m68k_waitgen_if.slave  bus
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned TMO_W = 8;
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT, ST_READY, ST_ACK, ST_BERR, ST_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_as_sync, r_ds_sync, r_prime;
    logic [3:0]       r_rdy_s0, r_rdy_s1;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [TMO_W-1:0] r_tmo, w_tmo_nxt, w_tmo_inc;
    logic [1:0]       r_sel, w_sel_nxt, w_cs_idx;
    logic             r_rw_l, w_rw_nxt;
    logic             r_armed, w_armed_nxt;
    logic             r_dtack, r_berr, r_rd_n, r_wr_n, r_busy;
    logic             w_as_n, w_ds_n, w_cs_one, w_active;
    logic [3:0]       w_cs_low;
    logic [CNT_W-1:0] w_wait_ld;

    assign w_as_n    = r_as_sync[1];
    assign w_ds_n    = r_ds_sync[1];
    assign w_cs_low  = ~bus.cs;
    assign w_tmo_inc = r_tmo + TMO_W'(1);

    // Decode which single select is active and its wait count.
    always_comb begin
        w_cs_one = 1'b1;
        w_cs_idx = 2'd0;
        case (w_cs_low)
            4'b0001: w_cs_idx = 2'd0;
            4'b0010: w_cs_idx = 2'd1;
            4'b0100: w_cs_idx = 2'd2;
            4'b1000: w_cs_idx = 2'd3;
            default: w_cs_one = 1'b0;
        endcase
        case (w_cs_idx)
            2'd0:    w_wait_ld = CNT_W'(WAIT0);
            2'd1:    w_wait_ld = CNT_W'(WAIT1);
            2'd2:    w_wait_ld = CNT_W'(WAIT2);
            default: w_wait_ld = CNT_W'(WAIT3);
        endcase
    end

    // Synchronisers; r_prime marks when the as_n chain holds real samples so
    // the reset value of the sync flops cannot arm a cycle inside a held AS.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_as_sync <= 2'b11;
            r_ds_sync <= 2'b11;
            r_rdy_s0  <= 4'b0000;
            r_rdy_s1  <= 4'b0000;
            r_prime   <= 2'b00;
        end else begin
            r_as_sync <= {r_as_sync[0], bus.as_n};
            r_ds_sync <= {r_ds_sync[0], bus.uds_n & bus.lds_n};
            r_rdy_s0  <= bus.rdy;
            r_rdy_s1  <= r_rdy_s0;
            r_prime   <= {r_prime[0], 1'b1};
        end
    end

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tmo_nxt   = r_tmo;
        w_sel_nxt   = r_sel;
        w_rw_nxt    = r_rw_l;
        w_armed_nxt = r_armed | (r_prime[1] & w_as_n);
        case (r_state)
            ST_IDLE: begin
                if (r_armed && !w_as_n && !w_ds_n && (w_cs_low != 4'b0000)) begin
                    w_armed_nxt = 1'b0;
                    if (w_cs_one) begin
                        w_state_nxt = ST_WAIT;
                        w_sel_nxt   = w_cs_idx;
                        w_rw_nxt    = bus.rw;
                        w_cnt_nxt   = w_wait_ld;
                    end else begin
                        w_state_nxt = ST_BERR;
                    end
                end
            end
            ST_WAIT: begin
                if (w_as_n) begin
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == '0) begin
                    if (RDY_MASK[r_sel]) begin
                        w_state_nxt = ST_READY;
                        w_tmo_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_ACK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_READY: begin
                if (w_as_n) begin
                    w_state_nxt = ST_DONE;
                end else if (r_rdy_s1[r_sel]) begin
                    w_state_nxt = ST_ACK;
                end else if (w_tmo_inc == TMO_LIM) begin
                    w_state_nxt = ST_BERR;
                    w_tmo_nxt   = TMO_LIM;
                end else begin
                    w_tmo_nxt = w_tmo_inc;
                end
            end
            ST_ACK, ST_BERR: begin
                if (w_as_n) w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        w_active = (w_state_nxt == ST_WAIT) || (w_state_nxt == ST_READY) ||
                   (w_state_nxt == ST_ACK);
    end

    // Datapath and registered outputs follow the next state.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_tmo   <= '0;
            r_sel   <= 2'd0;
            r_rw_l  <= 1'b1;
            r_armed <= 1'b0;
            r_dtack <= 1'b0;
            r_berr  <= 1'b0;
            r_rd_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_tmo   <= w_tmo_nxt;
            r_sel   <= w_sel_nxt;
            r_rw_l  <= w_rw_nxt;
            r_armed <= w_armed_nxt;
            r_dtack <= (w_state_nxt == ST_ACK);
            r_berr  <= (w_state_nxt == ST_BERR);
            r_rd_n  <= !(w_active && w_rw_nxt);
            r_wr_n  <= !(w_active && !w_rw_nxt);
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign bus.dtack_trig = r_dtack;
    assign bus.berr_req   = r_berr;
    assign bus.per_rd_n   = r_rd_n;
    assign bus.per_wr_n   = r_wr_n;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_m68k_waitgen.sv
// Directed bench for m68k_waitgen: latencies, strobes, ready timeout,
// multi-select error, reset mid-cycle and one-ack-per-AS behaviour.
module tb_m68k_waitgen;
    logic clk50 = 1'b0;
    logic reset = 1'b1;
    always #10 clk50 = ~clk50;

    m68k_waitgen_if bus ();

    m68k_waitgen #(.RDY_MASK(4'b0010)) dut (
        .clk50 (clk50),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string tag;
        int    exp;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // Cycle counter and sticky activity counters, sampled just after each edge.
    int   cyc = 0;
    int   n_dtack_rise = 0, n_wr_low = 0, n_rd_low = 0, n_busy = 0;
    logic prev_dtack = 1'b0;
    always @(posedge clk50) begin
        cyc++;
        #2;
        if (bus.dtack_trig && !prev_dtack) n_dtack_rise++;
        prev_dtack = bus.dtack_trig;
        if (!bus.per_wr_n) n_wr_low++;
        if (!bus.per_rd_n) n_rd_low++;
        if (bus.busy)      n_busy++;
    end

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.dtack_trig;
            1:       return bus.berr_req;
            default: return bus.busy;
        endcase
    endfunction

    function automatic int outs();
        return int'({bus.dtack_trig, bus.berr_req, bus.per_rd_n, bus.per_wr_n, bus.busy});
    endfunction

    function automatic void expect_val(input string tag, input int v);
        sb.push_back('{tag, v});
    endfunction

    task automatic check(input int obs);
        sb_t e;
        e = sb.pop_front();
        n_checks++;
        assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
        end
    endtask

    // Cycles from t0 until signal 'which' reaches 'level'; -1 if never.
    task automatic wait_for(input int which, input logic level, input int t0,
                            input int max, output int lat);
        lat = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk50);
            if (sig(which) === level) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    task automatic start_cycle(input logic [3:0] c, input logic r);
        bus.cs = c; bus.rw = r; bus.as_n = 1'b0; bus.uds_n = 1'b0;
    endtask

    task automatic end_cycle();
        bus.as_n = 1'b1; bus.uds_n = 1'b1; bus.lds_n = 1'b1; bus.cs = 4'hF;
    endtask

    initial begin
        int t0, lat, d0, w0, r0;
        bus.as_n = 1'b1; bus.uds_n = 1'b1; bus.lds_n = 1'b1;
        bus.rw = 1'b1; bus.cs = 4'hF; bus.rdy = 4'h0;

        repeat (3) @(negedge clk50);
        expect_val("reset_outputs", 5'b00110);
        check(outs());
        reset = 1'b0;
        repeat (6) @(negedge clk50);

        // Reset in the middle of a WAIT on cs[0]
        start_cycle(4'b1110, 1'b1);
        repeat (5) @(negedge clk50);
        reset = 1'b1;
        #1;
        expect_val("async_reset_outputs", 5'b00110);
        check(outs());
        repeat (2) @(negedge clk50);
        reset = 1'b0;
        d0 = n_dtack_rise;
        repeat (20) @(negedge clk50);
        expect_val("no_restart_in_held_as", 0);
        check(n_dtack_rise - d0);
        expect_val("busy_after_reset", 0);
        check(int'(bus.busy));
        end_cycle();
        repeat (4) @(negedge clk50);
        start_cycle(4'b1110, 1'b1);
        t0 = cyc;
        wait_for(0, 1'b1, t0, 40, lat);
        expect_val("rearm_dtack_lat", 6);
        check(lat);
        end_cycle();
        t0 = cyc;
        wait_for(2, 1'b0, t0, 20, lat);
        expect_val("rearm_busy_low", 4);
        check(lat);
        repeat (4) @(negedge clk50);

        // Read on cs[2], eight wait states
        start_cycle(4'b1011, 1'b1);
        t0 = cyc; w0 = n_wr_low;
        repeat (2) @(negedge clk50);
        expect_val("rd_strobe_before_start", 1);
        check(int'(bus.per_rd_n));
        @(negedge clk50);
        expect_val("rd_strobe_at_3", 0);
        check(int'(bus.per_rd_n));
        wait_for(0, 1'b1, t0, 40, lat);
        expect_val("read_cs2_dtack_lat", 12);
        check(lat);
        repeat (5) @(negedge clk50);
        expect_val("read_dtack_held", 1);
        check(int'(bus.dtack_trig));
        expect_val("read_no_wr_strobe", 0);
        check(n_wr_low - w0);
        end_cycle();
        t0 = cyc;
        wait_for(0, 1'b0, t0, 20, lat);
        expect_val("read_dtack_fall", 3);
        check(lat);
        repeat (5) @(negedge clk50);

        // Write on cs[0]; cs/rw change mid-cycle must be ignored
        start_cycle(4'b1110, 1'b0);
        t0 = cyc;
        repeat (4) @(negedge clk50);
        bus.cs = 4'b1011; bus.rw = 1'b1;
        wait_for(0, 1'b1, t0, 40, lat);
        expect_val("write_cs0_dtack_lat", 6);
        check(lat);
        expect_val("write_strobes", 5'b10101);
        check(outs());
        end_cycle();
        t0 = cyc;
        wait_for(0, 1'b0, t0, 20, lat);
        expect_val("write_dtack_fall", 3);
        check(lat);
        wait_for(2, 1'b0, t0, 20, lat);
        expect_val("write_busy_fall", 4);
        check(lat);
        repeat (4) @(negedge clk50);

        // cs[1] waits on rdy[1]: wait ends at 8, rdy raised 20 cycles later
        start_cycle(4'b1101, 1'b1);
        t0 = cyc;
        repeat (28) @(negedge clk50);
        expect_val("ready_hold_outputs", 5'b00011);
        check(outs());
        bus.rdy = 4'b0010;
        t0 = cyc;
        wait_for(0, 1'b1, t0, 20, lat);
        expect_val("rdy_to_dtack_lat", 3);
        check(lat);
        bus.rdy = 4'b0000;
        end_cycle();
        repeat (6) @(negedge clk50);

        // cs[1] with rdy never raised: timeout after 255 READY cycles
        start_cycle(4'b1101, 1'b1);
        t0 = cyc; d0 = n_dtack_rise;
        wait_for(1, 1'b1, t0, 400, lat);
        expect_val("timeout_berr_lat", 263);
        check(lat);
        expect_val("timeout_no_dtack", 0);
        check(n_dtack_rise - d0);
        expect_val("timeout_outputs", 5'b01111);
        check(outs());
        end_cycle();
        t0 = cyc;
        wait_for(2, 1'b0, t0, 20, lat);
        expect_val("timeout_busy_fall", 4);
        check(lat);
        repeat (4) @(negedge clk50);

        // Two selects low at cycle start
        start_cycle(4'b1100, 1'b1);
        t0 = cyc; r0 = n_rd_low; w0 = n_wr_low;
        wait_for(1, 1'b1, t0, 20, lat);
        expect_val("multi_cs_berr_lat", 3);
        check(lat);
        repeat (3) @(negedge clk50);
        expect_val("multi_cs_outputs", 5'b01111);
        check(outs());
        expect_val("multi_cs_no_strobes", 0);
        check((n_rd_low - r0) + (n_wr_low - w0));
        end_cycle();
        repeat (6) @(negedge clk50);

        // ds toggling while AS stays low: one dtack pulse only
        start_cycle(4'b1110, 1'b1);
        t0 = cyc; d0 = n_dtack_rise;
        wait_for(0, 1'b1, t0, 40, lat);
        expect_val("ds_toggle_dtack_lat", 6);
        check(lat);
        for (int i = 0; i < 5; i++) begin
            bus.uds_n = 1'b1;
            repeat (2) @(negedge clk50);
            bus.uds_n = 1'b0;
            repeat (3) @(negedge clk50);
        end
        expect_val("one_dtack_per_as", 1);
        check(n_dtack_rise - d0);
        end_cycle();
        repeat (6) @(negedge clk50);

        // No select: nothing happens
        d0 = n_busy;
        start_cycle(4'hF, 1'b1);
        repeat (15) @(negedge clk50);
        expect_val("no_cs_busy_cycles", 0);
        check(n_busy - d0);
        expect_val("no_cs_outputs", 5'b00110);
        check(outs());
        end_cycle();
        repeat (3) @(negedge clk50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
